// File: rtl/subleq_pkg.sv
// Shared SUBLEQ definitions: loader state encoding and the datapath word geometry.
package subleq_pkg;

  localparam int WORD_BYTES = 8;
  localparam int DATA_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } loader_state_t;

endpackage

// File: rtl/subleq_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module subleq_byte_packer #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              word_valid,
  output logic [DATA_W-1:0] word
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] shift_r;

  // Completed word is visible in the cycle its last byte is accepted, so the loader can act on that edge
  always_comb begin
    word_valid = byte_valid && (idx_r == IDX_W'(NBYTES - 1));
    word       = {byte_data, shift_r[DATA_W-1:8]};
  end

  // Byte index and shift register; bytes enter at the top and move down
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx_r   <= {IDX_W{1'b0}};
      shift_r <= {DATA_W{1'b0}};
    end else if (byte_valid) begin
      shift_r <= word;
      idx_r   <= word_valid ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end
  end

endmodule

// File: rtl/subleq_loader.sv
// Program loader for the SUBLEQ core: header word N, then N data words to addresses 0..N-1.
// Optional trailing checksum word enabled by defining SUBLEQ_LOADER_CHECKSUM_EN.
module subleq_loader #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  import subleq_pkg::*;

  localparam logic [DATA_W-1:0] MAX_N = DATA_W'(MAX_WORDS);

  loader_state_t     state_r;
  logic              in_ready_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              cpu_rst_r;
  logic              done_r;
  logic              err_r;
  logic [ADDR_W:0]   n_r;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_r;
`endif

  logic              transfer_s;
  logic              restart_s;
  logic              last_word_s;
  logic              word_valid_s;
  logic [DATA_W-1:0] word_s;

  // Handshake, restart and last-word decode
  always_comb begin
    transfer_s  = in_valid && in_ready_r;
    restart_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERR));
    last_word_s = ({1'b0, mem_addr_r} == (n_r - (ADDR_W + 1)'(1)));
  end

  subleq_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart_s),
    .byte_data  (in_data),
    .byte_valid (transfer_s),
    .word_valid (word_valid_s),
    .word       (word_s)
  );

  // Loader FSM; every output is a register so the memory port and core reset are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      cpu_rst_r   <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      n_r         <= {(ADDR_W + 1){1'b0}};
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
      csum_r      <= {DATA_W{1'b0}};
`endif
    end else begin
      mem_we_r <= 1'b0;
      if (restart_s) begin
        state_r    <= ST_HDR;
        in_ready_r <= 1'b1;
        mem_addr_r <= {ADDR_W{1'b0}};
        cpu_rst_r  <= 1'b1;
        done_r     <= 1'b0;
        err_r      <= 1'b0;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
        csum_r     <= {DATA_W{1'b0}};
`endif
      end else begin
        case (state_r)
          ST_HDR: begin
            if (word_valid_s) begin
              if (word_s == {DATA_W{1'b0}}) begin
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
                state_r    <= ST_CSUM;
`else
                state_r    <= ST_DONE;
                in_ready_r <= 1'b0;
                cpu_rst_r  <= 1'b0;
                done_r     <= 1'b1;
`endif
              end else if (word_s > MAX_N) begin
                state_r    <= ST_ERR;
                in_ready_r <= 1'b0;
                err_r      <= 1'b1;
              end else begin
                state_r    <= ST_LOAD;
                n_r        <= word_s[ADDR_W:0];
                mem_addr_r <= {ADDR_W{1'b0}};
              end
            end
          end
          ST_LOAD: begin
            if (word_valid_s) begin
              state_r     <= ST_WRITE;
              in_ready_r  <= 1'b0;
              mem_we_r    <= 1'b1;
              mem_wdata_r <= word_s;
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
              csum_r      <= csum_r + word_s;
`endif
            end
          end
          ST_WRITE: begin
            mem_addr_r <= mem_addr_r + ADDR_W'(1);
            if (last_word_s) begin
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
              state_r    <= ST_CSUM;
              in_ready_r <= 1'b1;
`else
              state_r    <= ST_DONE;
              cpu_rst_r  <= 1'b0;
              done_r     <= 1'b1;
`endif
            end else begin
              state_r    <= ST_LOAD;
              in_ready_r <= 1'b1;
            end
          end
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
          ST_CSUM: begin
            if (word_valid_s) begin
              in_ready_r <= 1'b0;
              if (word_s == csum_r) begin
                state_r   <= ST_DONE;
                cpu_rst_r <= 1'b0;
                done_r    <= 1'b1;
              end else begin
                state_r   <= ST_ERR;
                err_r     <= 1'b1;
              end
            end
          end
`endif
          ST_IDLE, ST_DONE, ST_ERR: begin
            state_r <= state_r;
          end
          default: begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_rst   = cpu_rst_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_subleq_loader.sv
// Scoreboard bench for subleq_loader; expected writes are queued by the stimulus and checked by a monitor.
module tb_subleq_loader;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int  n_checks = 0;
  int  n_errors = 0;
  bit  gap_mode = 1'b0;
  wr_t exp_q[$];
  wr_t exp_e;
  logic [DATA_W-1:0] wv [4];

  subleq_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected-write queue
  always @(negedge clk) begin
    if (!rst && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(exp_e.a));
        chk("wr_data", mem_wdata, exp_e.d);
        chk("ready_low_in_write", 64'(in_ready), 64'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    if (gap_mode && $urandom_range(0, 1) == 0) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      @(posedge clk); #1;
      guard++;
      if (guard > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL ready_timeout: got in_ready=%0b expected 1 within 50 cycles", in_ready);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_err_clear", 64'(err), 64'd0);
    chk("restart_done_clear", 64'(done), 64'd0);
    chk("restart_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("restart_ready", 64'(in_ready), 64'd1);
  endtask

  // Full image: header, count data words at addresses 0.., optional checksum, then done timing
  task automatic load_image(input int count);
    logic [63:0] sum = 64'd0;
    do_start();
    send_word(64'(count));
    for (int i = 0; i < count; i++) begin
      exp_q.push_back({ADDR_W'(i), wv[i]});
      send_word(wv[i]);
      sum = sum + wv[i];
    end
`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    send_word(sum);
    in_valid = 1'b0;
    @(negedge clk);
`else
    in_valid = 1'b0;
    if (count > 0) begin
      @(negedge clk);
      chk("done_low_in_write", 64'(done), 64'd0);
    end
    @(negedge clk);
`endif
    chk("done", 64'(done), 64'd1);
    chk("cpu_rst_released", 64'(cpu_rst), 64'd0);
    chk("ready_low_in_done", 64'(in_ready), 64'd0);
    chk("err_low_in_done", 64'(err), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 64'(in_ready), 64'd0);

    // N=3, gap-free
    wv[0] = 64'h1122334455667788; wv[1] = 64'h0; wv[2] = 64'hFFFFFFFFFFFFFFFF; wv[3] = 64'h0;
    load_image(3);

    // N=0: no writes, done straight after the header (or zero checksum)
    load_image(0);

    // N=1025 exceeds capacity
    do_start();
    send_word(64'd1025);
    in_valid = 1'b0;
    @(negedge clk);
    chk("hdr_big_err", 64'(err), 64'd1);
    chk("hdr_big_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("hdr_big_ready", 64'(in_ready), 64'd0);
    chk("hdr_big_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 64'(err), 64'd1);
    @(posedge clk); #1;
    wv[0] = 64'hDEADBEEFCAFEF00D;
    load_image(1);

    // N=1024: maximum image length accepted, header boundary only
    do_start();
    send_word(64'd1024);
    in_valid = 1'b0;
    @(negedge clk);
    chk("hdr_max_no_err", 64'(err), 64'd0);
    chk("hdr_max_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Random valid gaps, N=2 (starts from the pending N=1024 load after a reset)
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    gap_mode = 1'b1;
    wv[0] = 64'h0123456789ABCDEF; wv[1] = 64'h8000000000000001;
    load_image(2);
    gap_mode = 1'b0;

    // Reset after byte 5 of the first data word
    do_start();
    send_word(64'd2);
    for (int k = 0; k < 5; k++) send_byte(8'h30 + 8'(k));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(in_ready), 64'd0);
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_mem_addr", 64'(mem_addr), 64'd0);
    chk("midrst_mem_wdata", mem_wdata, 64'd0);
    chk("midrst_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(posedge clk); #1;
    wv[0] = 64'hA5A55A5A0F0FF0F0;
    load_image(1);

`ifdef SUBLEQ_LOADER_CHECKSUM_EN
    // Bad checksum 13 for words 5 and 7
    do_start();
    send_word(64'd2);
    exp_q.push_back({ADDR_W'(0), 64'd5});
    send_word(64'd5);
    exp_q.push_back({ADDR_W'(1), 64'd7});
    send_word(64'd7);
    send_word(64'd13);
    in_valid = 1'b0;
    @(negedge clk);
    chk("csum_bad_err", 64'(err), 64'd1);
    chk("csum_bad_cpu_rst", 64'(cpu_rst), 64'd1);
    chk("csum_bad_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    // Good checksum 12 (computed by load_image as 5+7)
    wv[0] = 64'd5; wv[1] = 64'd7;
    load_image(2);
`endif

    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
